// File: rtl/rv_pkg.sv
// Shared RV32/RV64 writeback definitions: load funct3 encodings, the
// writeback FSM state type and the load-decode helper functions.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  // Natural alignment: the access size is 2**f3[1:0] bytes.
  // Callers zero-extend narrower offsets to 3 bits.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // 111 is never a load; LD and LWU only exist on a 64-bit datapath.
  function automatic logic is_illegal_f3(input logic [2:0] f3, input int xlen);
    logic ill;
    if (f3 == 3'b111) begin
      ill = 1'b1;
    end else if ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU))) begin
      ill = 1'b1;
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data aligner: shifts the raw memory word down by the
// byte offset and sign/zero-extends according to funct3. Also intended for
// the store-forwarding path, so it carries no state.
module load_extract
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       f3,
  output logic [XLEN-1:0]  val
);

  logic [XLEN-1:0] shifted;

  // Align the addressed bytes to bit 0 and apply the funct3 extension.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (f3)
      F3_LB:   val = XLEN'($signed(shifted[7:0]));
      F3_LH:   val = XLEN'($signed(shifted[15:0]));
      F3_LW:   val = XLEN'($signed(shifted[31:0]));
      F3_LD:   val = shifted;
      F3_LBU:  val = XLEN'(shifted[7:0]);
      F3_LHU:  val = XLEN'(shifted[15:0]);
      F3_LWU:  val = XLEN'(shifted[31:0]);
      default: val = '0;
    endcase
  end

endmodule

// File: rtl/wb_load_unit.sv
// Writeback / load-return stage. Retires ALU results with one cycle of
// latency, and for loads stalls the pipeline until the memory response,
// a bus error or a response timeout. All outputs are registered.
module wb_load_unit
  import rv_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  REG_AW  = 5,
  parameter int  TIMEOUT = 16,
  localparam int OFF_W   = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_reg_w_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [2:0]        ex_f3,
  input  logic [OFF_W-1:0]  ex_off,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [XLEN-1:0]   wb_val,
  output logic              load_fault,
  output logic              load_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  wb_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_AW-1:0] rd_q;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic              ready_q;
  logic              wb_en_q;
  logic [REG_AW-1:0] wb_reg_q;
  logic [XLEN-1:0]   wb_val_q;
  logic              fault_q;
  logic              timeout_q;

  logic              load_bad;
  logic [XLEN-1:0]   ext_val;

  // Decode of the offered load, evaluated at acceptance.
  assign load_bad = is_illegal_f3(ex_f3, XLEN) || is_misaligned(ex_f3, 3'(ex_off));

  load_extract #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_extract (
    .rdata (mem_rdata),
    .off   (off_q),
    .f3    (f3_q),
    .val   (ext_val)
  );

  // Writeback FSM: acceptance, load wait/timeout and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      f3_q      <= 3'b000;
      off_q     <= '0;
      ready_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_val_q  <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Strobes are single-cycle; wb_reg/wb_val hold unless rewritten.
      wb_en_q   <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ex_valid && ready_q) begin
            if (ex_load) begin
              if (load_bad) begin
                fault_q <= 1'b1;
              end else begin
                rd_q    <= ex_rd;
                f3_q    <= ex_f3;
                off_q   <= ex_off;
                cnt_q   <= '0;
                state_q <= WAIT;
                ready_q <= 1'b0;
              end
            end else if (ex_reg_w_en) begin
              // x0 is never written but the address/data still track.
              wb_en_q  <= (ex_rd != '0);
              wb_reg_q <= ex_rd;
              wb_val_q <= ex_alu_result;
            end else begin
              wb_en_q <= 1'b0;
            end
          end else begin
            wb_en_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            // A response in the expiring cycle still wins over the timeout.
            state_q <= IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            if (mem_err) begin
              fault_q <= 1'b1;
            end else begin
              wb_en_q  <= (rd_q != '0);
              wb_reg_q <= rd_q;
              wb_val_q <= ext_val;
            end
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ex_ready     = ready_q;
  assign wb_en        = wb_en_q;
  assign wb_reg       = wb_reg_q;
  assign wb_val       = wb_val_q;
  assign load_fault   = fault_q;
  assign load_timeout = timeout_q;

endmodule
